render_rect_stream: RTL and testbench

RENDER_RECT_STREAM -- requirements
Module: render_rect_stream

---
 rtl/render_rect_stream_pkg.sv | 17 +
 rtl/render_rect_stream_raster_counter.sv | 60 ++++++
 rtl/render_rect_stream.sv | 165 ++++++++++++++++
 tb/tb_render_rect_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_rect_stream_pkg.sv
// Shared render definitions: default widths, screen size and FSM state encodings.
package render_rect_stream_pkg;

   localparam int X_W_DEF      = 9;
   localparam int Y_W_DEF      = 8;
   localparam int COLOR_W_DEF  = 3;
   localparam int SCREEN_W_DEF = 320;
   localparam int SCREEN_H_DEF = 240;
   localparam int BT_W_DEF     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/render_rect_stream_raster_counter.sv
// Column/row stepper for a clipped rectangle, walking it in row-major order.
module raster_counter
   import render_rect_stream_pkg::*;
#(
   parameter int X_W = X_W_DEF,
   parameter int Y_W = Y_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           advance,
   input  logic [X_W-1:0] limit_w,
   input  logic [Y_W-1:0] limit_h,
   output logic [X_W-1:0] col,
   output logic [Y_W-1:0] row,
   output logic           last
);

   localparam logic [X_W-1:0] ONE_X = {{(X_W-1){1'b0}}, 1'b1};
   localparam logic [Y_W-1:0] ONE_Y = {{(Y_W-1){1'b0}}, 1'b1};

   logic [X_W-1:0] col_q, col_d;
   logic [Y_W-1:0] row_q, row_d;
   logic           col_end, row_end;

   // Next position: restart on load, otherwise step column and wrap into next row.
   always_comb begin
      col_end = (col_q == (limit_w - ONE_X));
      row_end = (row_q == (limit_h - ONE_Y));
      col_d   = col_q;
      row_d   = row_q;
      if (load) begin
         col_d = '0;
         row_d = '0;
      end else if (advance) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_q + ONE_Y;
         end else begin
            col_d = col_q + ONE_X;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign last = col_end && row_end;

endmodule

// File: rtl/render_rect_stream.sv
// Streams the pixels of a clipped, optionally bordered rectangle over a valid/ready port.
module render_rect_stream
   import render_rect_stream_pkg::*;
#(
   parameter int X_W      = X_W_DEF,
   parameter int Y_W      = Y_W_DEF,
   parameter int COLOR_W  = COLOR_W_DEF,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int BT_W     = BT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic [X_W-1:0]     origin_x,
   input  logic [Y_W-1:0]     origin_y,
   input  logic [X_W-1:0]     width,
   input  logic [Y_W-1:0]     height,
   input  logic [COLOR_W-1:0] back_color,
   input  logic [COLOR_W-1:0] border_color,
   input  logic [BT_W-1:0]    border_thick,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [X_W-1:0]     out_x,
   output logic [Y_W-1:0]     out_y,
   output logic [COLOR_W-1:0] out_color
);

   localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

   state_e state_q, state_d;

   logic               load, empty, advance, last, all_border;
   logic [X_W:0]       rem_x, t2_x;
   logic [Y_W:0]       rem_y, t2_y;
   logic [X_W-1:0]     effw;
   logic [Y_W-1:0]     effh;

   logic [X_W-1:0]     ox_q, w_q, effw_q;
   logic [Y_W-1:0]     oy_q, h_q, effh_q;
   logic [COLOR_W-1:0] back_q, border_q;
   logic [BT_W-1:0]    t_q;
   logic               all_border_q;

   logic [X_W-1:0]     col;
   logic [Y_W-1:0]     row;
   logic [X_W:0]       col_e, t_x;
   logic [Y_W:0]       row_e, t_y;
   logic               is_border;

   // Latch-time geometry: emptiness test, clipping against the screen, thick-border collapse.
   always_comb begin
      load  = (state_q == ST_IDLE) && start;
      empty = (width == '0) || (height == '0) ||
              ({1'b0, origin_x} >= SCR_W) || ({1'b0, origin_y} >= SCR_H);
      rem_x = SCR_W - {1'b0, origin_x};
      rem_y = SCR_H - {1'b0, origin_y};
      // When the remaining span is not larger than width it necessarily fits in X_W bits.
      effw  = ({1'b0, width}  < rem_x) ? width  : rem_x[X_W-1:0];
      effh  = ({1'b0, height} < rem_y) ? height : rem_y[Y_W-1:0];
      t2_x  = (X_W+1)'({border_thick, 1'b0});
      t2_y  = (Y_W+1)'({border_thick, 1'b0});
      all_border = (t2_x >= {1'b0, width}) || (t2_y >= {1'b0, height});
   end

   // Request registers, captured only when a start is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         ox_q         <= '0;
         oy_q         <= '0;
         w_q          <= '0;
         h_q          <= '0;
         effw_q       <= '0;
         effh_q       <= '0;
         back_q       <= '0;
         border_q     <= '0;
         t_q          <= '0;
         all_border_q <= 1'b0;
      end else if (load) begin
         ox_q         <= origin_x;
         oy_q         <= origin_y;
         w_q          <= width;
         h_q          <= height;
         effw_q       <= effw;
         effh_q       <= effh;
         back_q       <= back_color;
         border_q     <= border_color;
         t_q          <= border_thick;
         all_border_q <= all_border;
      end
   end

   raster_counter #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_raster (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .limit_w (effw_q),
      .limit_h (effh_q),
      .col     (col),
      .row     (row),
      .last    (last)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and handshake/status outputs.
   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      advance   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = empty ? ST_FIN : ST_DRAW;
            end
         end
         ST_DRAW: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            advance   = out_ready;
            if (out_ready && last) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel colour from unclipped geometry, so clipped edges carry no border.
   always_comb begin
      col_e     = {1'b0, col};
      row_e     = {1'b0, row};
      t_x       = (X_W+1)'(t_q);
      t_y       = (Y_W+1)'(t_q);
      is_border = (t_q != '0) &&
                  (all_border_q ||
                   (col_e < t_x) || ((col_e + t_x) >= {1'b0, w_q}) ||
                   (row_e < t_y) || ((row_e + t_y) >= {1'b0, h_q}));
      out_color = is_border ? border_q : back_q;
      out_x     = ox_q + col;
      out_y     = oy_q + row;
   end

endmodule

// File: tb/tb_render_rect_stream.sv
// Scoreboard bench for render_rect_stream: reference pixel list vs. streamed output.
module tb_render_rect_stream;

   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COLOR_W  = 3;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int BT_W     = 4;

   logic               clk = 1'b0;
   logic               reset, start, busy, done;
   logic [X_W-1:0]     origin_x, width, out_x;
   logic [Y_W-1:0]     origin_y, height, out_y;
   logic [COLOR_W-1:0] back_color, border_color, out_color;
   logic [BT_W-1:0]    border_thick;
   logic               out_valid, out_ready;

   render_rect_stream #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .COLOR_W  (COLOR_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .BT_W     (BT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .origin_x     (origin_x),
      .origin_y     (origin_y),
      .width        (width),
      .height       (height),
      .back_color   (back_color),
      .border_color (border_color),
      .border_thick (border_thick),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_color    (out_color)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] c;
   } pix_t;

   pix_t exp_q[$];
   int   checks     = 0;
   int   failures   = 0;
   int   ready_mode = 0;
   int   ready_cyc  = 0;
   int   done_seen  = 0;
   int   xfer_seen  = 0;
   pix_t hold_pix;
   bit   hold_valid = 1'b0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference: every on-screen pixel of the rectangle, row-major, coloured by the border rule.
   task automatic model(input int ox, input int oy, input int w, input int h, input int t,
                        input int back, input int bord, output int n);
      pix_t p;
      n = 0;
      for (int y = oy; y < oy + h && y < SCREEN_H; y++) begin
         for (int x = ox; x < ox + w && x < SCREEN_W; x++) begin
            int col, row;
            bit b;
            col = x - ox;
            row = y - oy;
            b = (t > 0) && ((2*t >= w) || (2*t >= h) || (col < t) || (col >= w - t) ||
                            (row < t) || (row >= h - t));
            p.x = X_W'(x);
            p.y = Y_W'(y);
            p.c = COLOR_W'(b ? bord : back);
            exp_q.push_back(p);
            n++;
         end
      end
   endtask

   // Downstream ready: always 1, the 1,0,0 pattern, or random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((ready_cyc % 3) == 0);
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      ready_cyc++;
   end

   // Monitor: pop and compare on each transfer, check stability while stalled.
   always @(negedge clk) begin
      pix_t e;
      if (reset) begin
         hold_valid = 1'b0;
      end else begin
         if (done) done_seen++;
         if (hold_valid) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_x", int'(out_x), int'(hold_pix.x));
            chk("stall_y", int'(out_y), int'(hold_pix.y));
            chk("stall_color", int'(out_color), int'(hold_pix.c));
         end
         hold_valid = 1'b0;
         if (out_valid && out_ready) begin
            xfer_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_pixel", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pix_x", int'(out_x), int'(e.x));
               chk("pix_y", int'(out_y), int'(e.y));
               chk("pix_color", int'(out_color), int'(e.c));
            end
         end else if (out_valid) begin
            hold_valid = 1'b1;
            hold_pix.x = out_x;
            hold_pix.y = out_y;
            hold_pix.c = out_color;
         end
      end
   end

   task automatic scramble();
      origin_x     = X_W'($urandom);
      origin_y     = Y_W'($urandom);
      width        = X_W'($urandom);
      height       = Y_W'($urandom);
      back_color   = COLOR_W'($urandom);
      border_color = COLOR_W'($urandom);
      border_thick = BT_W'($urandom);
   endtask

   task automatic run_rect(input int ox, input int oy, input int w, input int h, input int t,
                           input int back, input int bord, input int rmode, input bit poke_fin);
      int n, cyc, first_v, done_c, x0;
      bit fin;
      first_v = 0;
      done_c  = 0;
      fin     = 1'b0;
      model(ox, oy, w, h, t, back, bord, n);
      x0 = xfer_seen;
      ready_mode = rmode;
      ready_cyc  = 0;
      @(posedge clk); #1;
      origin_x     = X_W'(ox);
      origin_y     = Y_W'(oy);
      width        = X_W'(w);
      height       = Y_W'(h);
      border_thick = BT_W'(t);
      back_color   = COLOR_W'(back);
      border_color = COLOR_W'(bord);
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      cyc = 1;
      while (!fin && cyc < 8*n + 40) begin
         @(negedge clk);
         cyc++;
         if (out_valid && first_v == 0) first_v = cyc;
         if (done) begin
            fin    = 1'b1;
            done_c = cyc;
            chk("busy_during_done", int'(busy), 1);
            if (poke_fin) start = 1'b1;
         end
      end
      chk("done_reached", int'(fin), 1);
      if (rmode == 0) chk("done_cycle", done_c, n + 2);
      chk("first_valid_cycle", first_v, (n > 0) ? 2 : 0);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("busy_back_idle", int'(busy), 0);
      chk("valid_back_idle", int'(out_valid), 0);
      start = 1'b0;
      chk("pixel_count", xfer_seen - x0, n);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n, x0, d0;
      reset        = 1'b1;
      start        = 1'b0;
      out_ready    = 1'b1;
      origin_x     = '0;
      origin_y     = '0;
      width        = '0;
      height       = '0;
      back_color   = '0;
      border_color = '0;
      border_thick = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_x", int'(out_x), 0);
      chk("rst_y", int'(out_y), 0);
      chk("rst_color", int'(out_color), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_rect(10, 20, 4, 3, 0, 5, 2, 0, 1'b0);
      run_rect(0, 0, 5, 5, 1, 1, 7, 0, 1'b1);
      run_rect(318, 238, 5, 4, 1, 2, 6, 0, 1'b0);
      run_rect(40, 50, 3, 2, 0, 4, 3, 1, 1'b0);
      run_rect(100, 60, 6, 5, 2, 3, 5, 1, 1'b0);
      run_rect(5, 5, 0, 3, 1, 1, 2, 0, 1'b0);
      run_rect(320, 5, 3, 3, 1, 1, 2, 0, 1'b0);
      run_rect(7, 240, 3, 3, 0, 1, 2, 0, 1'b0);

      // Reset while the 5th pixel of a 4x4 is on the port.
      model(60, 70, 4, 4, 1, 5, 2, n);
      x0 = xfer_seen;
      d0 = done_seen;
      ready_mode = 0;
      @(posedge clk); #1;
      origin_x     = X_W'(60);
      origin_y     = Y_W'(70);
      width        = X_W'(4);
      height       = Y_W'(4);
      border_thick = BT_W'(1);
      back_color   = COLOR_W'(5);
      border_color = COLOR_W'(2);
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_xfers", xfer_seen - x0, 4);
      repeat (3) @(negedge clk);
      chk("mid_rst_no_done", done_seen - d0, 0);
      chk("mid_rst_still_idle", int'(busy), 0);
      run_rect(60, 70, 4, 4, 1, 5, 2, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_rect($urandom_range(0, 325), $urandom_range(0, 245), $urandom_range(0, 9),
                  $urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 7),
                  $urandom_range(0, 7), 2, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
